// File: rtl/rasterizer_writeback_logic.sv
// rasterizer_writeback_logic: queues shaded fragments, depth-tests them and writes depth then color over Avalon-MM
module rasterizer_writeback_logic #(
  parameter logic [25:0] COLOR_OFFSET = 26'h0200000,
  parameter int FIFO_DEPTH = 4,
  parameter int DEPTH_LE = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        input_valid,
  input  logic [25:0] addr_in,
  input  logic [23:0] color_in,
  input  logic [31:0] old_depth_in,
  input  logic [31:0] new_depth_in,
  output logic        wait_request,
  output logic [25:0] master_address,
  output logic        master_write,
  output logic        master_read,
  output logic [3:0]  master_byteenable,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest,
  output logic        busy,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WR_DEPTH = 2'd1, WR_COLOR = 2'd2;
  // entry layout: {addr[113:88], color[87:64], old[63:32], new[31:0]}
  logic [113:0]  mem [FIFO_DEPTH];
  logic [113:0]  head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [25:0]   w_addr;
  logic [23:0]   w_color;
  logic [31:0]   w_depth;
  logic          push, pop, pass;
  assign wait_request = count == FULL;
  assign push = input_valid && !wait_request;
  assign pop = state == IDLE && count != '0;
  assign head = mem[rd_ptr];
  assign pass = (DEPTH_LE != 0) ? head[31:0] <= head[63:32] : head[31:0] < head[63:32];
  assign busy = count != '0 || state != IDLE;
  // Avalon outputs depend only on state and the working register, so they hold steady under stall
  assign master_write = state == WR_DEPTH || state == WR_COLOR;
  assign master_read = 1'b0;
  assign master_address = state == WR_COLOR ? w_addr + COLOR_OFFSET : w_addr;
  assign master_writedata = state == WR_COLOR ? {8'h00, w_color} : w_depth;
  assign master_byteenable = state == WR_DEPTH ? 4'b1111 : state == WR_COLOR ? 4'b0111 : 4'b0000;
  // queue storage; contents are don't-care until the pointers say otherwise, so no reset
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {addr_in, color_in, old_depth_in, new_depth_in};
  end
  // queue pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // pop-and-test in IDLE, then depth write followed by color write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      w_addr <= '0;
      w_color <= '0;
      w_depth <= '0;
      pass_count <= '0;
      fail_count <= '0;
    end else if (pop) begin
      w_addr <= head[113:88];
      w_color <= head[87:64];
      w_depth <= head[31:0];
      if (pass) state <= WR_DEPTH;
      else fail_count <= fail_count + 16'd1;
    end else if (state == WR_DEPTH && !master_waitrequest) begin
      state <= WR_COLOR;
    end else if (state == WR_COLOR && !master_waitrequest) begin
      state <= IDLE;
      pass_count <= pass_count + 16'd1;
    end
  end
endmodule
